// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states,
// and the access-legality check used at request acceptance.
package load_store_unit_pkg;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } ls_state_t;

    // Illegal size code, or a half/word access that does not sit on its natural boundary.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11) ||
               ((size == LS_H) && addr_lo[0]) ||
               ((size == LS_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational little-endian lane handling: merges store data into an existing
// word and extracts/extends load data from a fetched word.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Each byte lane takes store data when the access covers it, else keeps the old byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic w_sel;
        logic [7:0] w_src;
        always_comb begin
            w_sel = 1'b1;
            w_src = i_wdata[8*gi +: 8];
            if (i_size == LS_B) begin
                w_sel = (i_addr == 2'(gi));
                w_src = i_wdata[7:0];
            end else if (i_size == LS_H) begin
                w_sel = (i_addr[1] == (gi >= 2));
                w_src = i_wdata[8*(gi%2) +: 8];
            end
        end
        assign o_merged[8*gi +: 8] = w_sel ? w_src : i_word[8*gi +: 8];
    end

    assign w_byte = i_word[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_rdata = i_word;
        case (i_size)
            LS_B:    o_rdata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            LS_H:    o_rdata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed DataMem: one request
// at a time, read-modify-write for sub-word stores, Moore outputs from the FSM.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    ls_state_t         r_state;
    ls_state_t         w_state_next;
    logic              r_we;
    logic              r_unsigned;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word;
    logic              w_accept;
    logic              w_req_err;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_req_err = access_error(req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_err      <= w_req_err;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (r_state == ST_READ) begin
                r_word <= mem_data_out;
            end
        end
    end

    // Full-word stores skip the read; sub-word stores read first so the merge sees the old word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)                        w_state_next = ST_RESP;
                    else if (req_we && req_size == LS_W)  w_state_next = ST_WRITE;
                    else                                  w_state_next = ST_READ;
                end
            end
            ST_READ:  w_state_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_state_next = ST_RESP;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    load_store_unit_lane_align u_lane_align (
        .i_word     (r_word),
        .i_addr     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_merged   (w_merged),
        .o_rdata    (w_rdata)
    );

    assign req_ready   = (r_state == ST_IDLE);
    assign MemRead     = (r_state == ST_READ);
    assign MemWrite    = (r_state == ST_WRITE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_err     = (r_state == ST_RESP) && r_err;
    assign rsp_rdata   = ((r_state == ST_RESP) && !r_err && !r_we) ? w_rdata : '0;
    assign mem_addr    = r_addr[ADDR_W-1:2];
    assign mem_data_in = (r_state == ST_WRITE) ? w_merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] model_mem [64];
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (MemWrite) mem[mem_addr] <= mem_data_in;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
        int          act;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int act_cnt = 0;
    int wr_cnt = 0;
    int overlap = 0;
    int txn_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference behaviour: legality, byte-lane arithmetic, extension, latency.
    function automatic exp_t ref_model(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        int idx = int'(a) / 4;
        int off = int'(a) % 4;
        logic [31:0] w = model_mem[idx];
        logic [31:0] b, h, mask;
        e.err   = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
        e.rdata = 32'd0;
        e.due   = 0; e.act = 0; e.id = 0;
        if (e.err) begin
            e.due = 1;
        end else if (!we) begin
            e.due = 2;
            b = (w >> (8 * off)) & 32'hFF;
            h = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (sz == 2'd0)      e.rdata = (uns || b < 32'h80)   ? b : (b | 32'hFFFFFF00);
            else if (sz == 2'd1) e.rdata = (uns || h < 32'h8000) ? h : (h | 32'hFFFF0000);
            else                 e.rdata = w;
        end else begin
            if (sz == 2'd2) begin
                e.due = 2;
                model_mem[idx] = wd;
            end else begin
                e.due = 3;
                mask = (sz == 2'd0) ? (32'hFF << (8 * off)) : (32'hFFFF << (8 * off));
                model_mem[idx] = (w & ~mask) | ((wd << (8 * off)) & mask);
            end
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout actual=0 required=1");
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        e = ref_model(we, sz, uns, a, wd);
        @(posedge clk);
        #1;
        e.due = cyc + e.due - 1;
        e.act = act_cnt;
        e.id  = txn_id++;
        sb_q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_mem_rd"}, {31'd0, MemRead}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, MemWrite}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every response and checks data, error and timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (MemRead || MemWrite) act_cnt <= act_cnt + 1;
            if (MemWrite) wr_cnt <= wr_cnt + 1;
            if (MemRead && MemWrite) overlap <= overlap + 1;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn %0d rdata=0x%08h err=%0d", e.id, rsp_rdata, rsp_err);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_latency", cyc, e.due);
                    if (e.err) chk("err_no_mem_access", act_cnt, e.act);
                end
            end
        end
    end

    initial begin
        int wr_before;
        for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; model_mem[i] = 32'd0; end

        #3;
        check_reset_outputs("reset");
        chk("reset_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("reset_mem_data_in", mem_data_in, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 8'h04, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0);
        drain();
        chk("sw_mem1", mem[1], 32'hDEADBEEF);
        issue(1'b1, 2'd0, 1'b0, 8'h05, 32'h000000AA);
        drain();
        chk("sb_mem1", mem[1], 32'hDEADAAEF);
        issue(1'b0, 2'd0, 1'b0, 8'h05, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 8'h05, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 8'h06, 32'h00001234);
        drain();
        chk("sh_mem1", mem[1], 32'h1234AAEF);
        issue(1'b0, 2'd1, 1'b0, 8'h06, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 8'h04, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 8'h02, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 8'h03, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 8'h08, 32'h12345678);
        issue(1'b1, 2'd2, 1'b0, 8'h0A, 32'h87654321);
        drain();

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("idle_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a sub-word store while it is reading the old word.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 8'h04; req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_in_read", {31'd0, MemRead}, 32'd1);
        wr_before = wr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("abort_no_write", wr_cnt, wr_before);
        chk("abort_mem1", mem[1], 32'h1234AAEF);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0);
        drain();

        for (int t = 0; t < 120; t++) begin
            logic [1:0] sz;
            logic [7:0] a;
            int gap = $urandom_range(0, 2);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            for (int g = 0; g < gap; g++) @(negedge clk);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();

        for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), mem[i], model_mem[i]);
        chk("rd_wr_overlap", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
